// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter and its
// output stage.
package mux_arb_pkg;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    function automatic logic [N_REQ-1:0] onehot2(input logic [SEL_W-1:0] sel);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[sel] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester/consumer bundle for mux_rr_arbiter. The slave side is the
// arbiter; the master side drives the requests and the downstream ready.
interface mux_rr_arbiter_if #(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
);
    logic [3:0]        req_i;
    logic [DATA_W-1:0] a_i;
    logic [DATA_W-1:0] b_i;
    logic [DATA_W-1:0] c_i;
    logic [DATA_W-1:0] d_i;
    logic [3:0]        gnt_o;
    logic [DATA_W-1:0] y_o;
    logic [1:0]        sel_o;
    logic              y_valid_o;
    logic              y_ready_i;
    logic [CNT_W-1:0]  xfer_cnt_o;

    modport slave (
        input  req_i, a_i, b_i, c_i, d_i, y_ready_i,
        output gnt_o, y_o, sel_o, y_valid_o, xfer_cnt_o
    );

    modport master (
        output req_i, a_i, b_i, c_i, d_i, y_ready_i,
        input  gnt_o, y_o, sel_o, y_valid_o, xfer_cnt_o
    );
endinterface

// File: rtl/mux_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first requester found when scanning
// upward from ptr, wrapping modulo four.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] win,
    output logic             any
);

    // rot[k] is the request of the requester k places after ptr.
    logic [N_REQ-1:0] rot;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
            logic [SEL_W-1:0] idx;
            assign idx     = ptr + SEL_W'(gi);
            assign rot[gi] = req[idx];
        end
    endgenerate

    logic [SEL_W-1:0] ofs;

    always_comb begin
        ofs = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                ofs = SEL_W'(k);
            end
        end
        win = ptr + ofs;
        any = |req;
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Four-requester round-robin arbiter with a single registered output word
// offered on a valid/ready channel, plus a completed-transfer counter.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    mux_rr_arbiter_if.slave bus
);

    logic [DATA_W-1:0] data_arr [N_REQ];

    assign data_arr[0] = bus.a_i;
    assign data_arr[1] = bus.b_i;
    assign data_arr[2] = bus.c_i;
    assign data_arr[3] = bus.d_i;

    state_t            state_reg, state_next;
    logic [SEL_W-1:0]  ptr_reg,   ptr_next;
    logic [SEL_W-1:0]  sel_reg,   sel_next;
    logic [DATA_W-1:0] y_reg,     y_next;
    logic [CNT_W-1:0]  cnt_reg,   cnt_next;

    logic [SEL_W-1:0]  win;
    logic              any;
    logic              can_take;
    logic              grant;
    logic              done;

    rr_pick4 u_pick (
        .req (bus.req_i),
        .ptr (ptr_reg),
        .win (win),
        .any (any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
            ptr_reg   <= '0;
            sel_reg   <= '0;
            y_reg     <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            sel_reg   <= sel_next;
            y_reg     <= y_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        sel_next   = sel_reg;
        y_next     = y_reg;
        cnt_next   = cnt_reg;

        // A grant is only possible when the output slot is free or is being
        // drained this same cycle; grants are suppressed while in reset.
        can_take = (state_reg == ST_EMPTY) || bus.y_ready_i;
        grant    = can_take && any && rst_n;
        done     = (state_reg == ST_FULL) && bus.y_ready_i;

        if (grant) begin
            y_next     = data_arr[win];
            sel_next   = win;
            state_next = ST_FULL;
            ptr_next   = win + SEL_W'(1);
        end else if (done) begin
            state_next = ST_EMPTY;
        end

        if (done) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end

        bus.gnt_o = grant ? onehot2(win) : '0;
    end

    assign bus.y_o        = y_reg;
    assign bus.sel_o      = sel_reg;
    assign bus.y_valid_o  = (state_reg == ST_FULL);
    assign bus.xfer_cnt_o = cnt_reg;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed and randomized bench for mux_rr_arbiter against a behavioural
// round-robin/one-slot-buffer model.
module tb_mux_rr_arbiter;

    logic clk;
    logic rst_n;

    mux_rr_arbiter_if #(.DATA_W(4), .CNT_W(8)) bus ();

    mux_rr_arbiter #(.DATA_W(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int         m_ptr;
    bit         m_full;
    logic [3:0] m_y;
    int         m_sel;
    int         m_cnt;
    logic [3:0] dat [4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_full = 0;
        m_y    = 4'h0;
        m_sel  = 0;
        m_cnt  = 0;
    endtask

    // One cycle: drive at negedge, compare just after, advance model at posedge.
    task automatic step(input logic [3:0] r, input logic rdy, input int want_g);
        int         w;
        logic [3:0] exp_g;
        bit         done;
        @(negedge clk);
        bus.req_i     = r;
        bus.y_ready_i = rdy;
        bus.a_i       = dat[0];
        bus.b_i       = dat[1];
        bus.c_i       = dat[2];
        bus.d_i       = dat[3];
        #1;
        w     = -1;
        exp_g = 4'b0000;
        if (rst_n && (!m_full || rdy) && r != 4'b0000) begin
            for (int k = 0; k < 4; k++) begin
                if (w < 0 && r[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
            end
            exp_g = 4'b0001 << w;
        end
        chk("gnt",   32'(bus.gnt_o),      32'(exp_g));
        chk("valid", 32'(bus.y_valid_o),  32'(m_full));
        chk("y",     32'(bus.y_o),        32'(m_y));
        chk("sel",   32'(bus.sel_o),      32'(m_sel));
        chk("cnt",   32'(bus.xfer_cnt_o), 32'(m_cnt));
        if (want_g >= 0) chk("gnt_directed", 32'(bus.gnt_o), 32'(want_g));
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            done = m_full && rdy;
            if (w >= 0) begin
                m_y    = dat[w];
                m_sel  = w;
                m_full = 1;
                m_ptr  = (w + 1) % 4;
            end else if (done) begin
                m_full = 0;
            end
            if (done) m_cnt = (m_cnt + 1) % 256;
        end
    endtask

    task automatic set_dat(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
        dat[0] = a; dat[1] = b; dat[2] = c; dat[3] = d;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        step(4'b1111, 1'b1, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        bus.req_i     = 4'b1111;
        bus.y_ready_i = 1'b1;
        bus.a_i = 4'h0; bus.b_i = 4'h0; bus.c_i = 4'h0; bus.d_i = 4'h0;
        set_dat(4'h0, 4'h0, 4'h0, 4'h0);
        model_reset();

        // 1: held in reset with all requests set, then release.
        step(4'b1111, 1'b1, 0);
        step(4'b1111, 1'b1, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        step(4'b1111, 1'b1, 4'b0001);

        // 2: single requester 1, then drop requests and drain.
        set_dat(4'h5, 4'hA, 4'h6, 4'h7);
        step(4'b0010, 1'b1, 4'b0010);
        step(4'b0000, 1'b1, 0);
        step(4'b0000, 1'b1, 0);
        step(4'b0000, 1'b1, 0);

        // 3: all requesting, full rotation with no bubbles.
        apply_reset();
        set_dat(4'h1, 4'h2, 4'h3, 4'h4);
        step(4'b1111, 1'b1, 4'b0001);
        step(4'b1111, 1'b1, 4'b0010);
        step(4'b1111, 1'b1, 4'b0100);
        step(4'b1111, 1'b1, 4'b1000);
        step(4'b1111, 1'b1, 4'b0001);
        step(4'b0000, 1'b1, 0);
        step(4'b0000, 1'b1, 0);

        // 4: backpressure holding y_o=3.
        set_dat(4'h9, 4'h2, 4'h3, 4'h4);
        step(4'b0100, 1'b1, 4'b0100);
        for (int i = 0; i < 5; i++) begin
            step(4'b0001, 1'b0, 0);
            chk("bp_y", 32'(bus.y_o), 32'h3);
        end
        step(4'b0001, 1'b1, 4'b0001);
        step(4'b0000, 1'b0, 0);
        chk("bp_after_y", 32'(bus.y_o), 32'h9);

        // 5: pointer advance and wrap.
        step(4'b0010, 1'b1, 4'b0010);
        step(4'b0011, 1'b1, 4'b0001);
        step(4'b0011, 1'b1, 4'b0010);

        // 6a: asynchronous reset mid-cycle while holding a word.
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus.y_valid_o),  32'h0);
        chk("async_cnt",   32'(bus.xfer_cnt_o), 32'h0);
        chk("async_gnt",   32'(bus.gnt_o),      32'h0);
        model_reset();
        step(4'b1111, 1'b1, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // 6b: 256 completed transfers wrap the counter.
        set_dat(4'hC, 4'h1, 4'h2, 4'h3);
        for (int i = 0; i < 257; i++) step(4'b0001, 1'b1, -1);
        step(4'b0000, 1'b0, -1);
        chk("cnt_wrap", 32'(bus.xfer_cnt_o), 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            set_dat(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            step(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
